// File: rtl/dkong3_obj_dma_pkg.sv
// Shared types and constants for the object-table DMA stage.
// The Y-flip constant and helper are consumed only when OBJ_DMA_FLIPY_EN is defined.
package dkong3_obj_dma_pkg;

    localparam int unsigned CNT_W      = 10;
    localparam int unsigned LAT_W      = 2;
    localparam int unsigned SRC_AW     = 16;
    localparam int unsigned OBJ_AW     = 10;
    localparam int unsigned DW         = 8;

    localparam int unsigned      LEN_DEF      = 384;
    localparam logic [SRC_AW-1:0] SRC_BASE_DEF = 16'h7000;
    localparam int unsigned      RD_LAT_DEF   = 1;

    localparam logic [DW-1:0] FLIPY_BASE = 8'd240;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WAIT,
        WRITE,
        DONE
    } dma_state_t;

    // One object-RAM write beat
    typedef struct packed {
        logic [OBJ_AW-1:0] a;
        logic [DW-1:0]     d;
    } obj_wr_t;

    function automatic logic [DW-1:0] flip_y(input logic [DW-1:0] b);
        return FLIPY_BASE - b;
    endfunction

endpackage

// File: rtl/dkong3_obj_dma_if.sv
// CPU-bus arbitration/read port and object-RAM DMA write port of the object DMA.
interface dkong3_obj_dma_if;
    import dkong3_obj_dma_pkg::*;

    logic              O_BUSRQ;
    logic              I_BUSAK;
    logic [SRC_AW-1:0] O_SRC_A;
    logic              O_SRC_RD;
    logic [DW-1:0]     I_SRC_D;
    logic [OBJ_AW-1:0] O_OBJ_DMA_A;
    logic [DW-1:0]     O_OBJ_DMA_D;
    logic              O_OBJ_DMA_CE;

    modport master (
        output O_BUSRQ, O_SRC_A, O_SRC_RD, O_OBJ_DMA_A, O_OBJ_DMA_D, O_OBJ_DMA_CE,
        input  I_BUSAK, I_SRC_D
    );

    modport slave (
        input  O_BUSRQ, O_SRC_A, O_SRC_RD, O_OBJ_DMA_A, O_OBJ_DMA_D, O_OBJ_DMA_CE,
        output I_BUSAK, I_SRC_D
    );

endinterface

// File: rtl/dkong3_obj_dma_trig.sv
// Trigger detection: CPU write strobe falling edge or auto vblank rising edge,
// folded into a single-level pending flag that the FSM clears when it leaves IDLE.
module dkong3_obj_dma_trig (
    input  logic I_CLK_24M,
    input  logic I_RESETn,
    input  logic I_START_WRn,
    input  logic I_VBLK,
    input  logic I_AUTO,
    input  logic pend_clr,
    output logic pending
);

    logic wrn_q;
    logic vblk_q;
    logic trig_c;

    assign trig_c = (wrn_q & ~I_START_WRn) | (I_AUTO & I_VBLK & ~vblk_q);

    // A fresh trigger wins over a same-cycle clear so it is never dropped
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            wrn_q   <= 1'b1;
            vblk_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            wrn_q  <= I_START_WRn;
            vblk_q <= I_VBLK;
            if (trig_c) begin
                pending <= 1'b1;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dkong3_obj_dma.sv
// Object-table DMA: copies the sprite table from CPU work RAM into object RAM
// under BUSRQ/BUSAK arbitration. Define OBJ_DMA_FLIPY_EN to add I_FLIPY Y-field mirroring.
module dkong3_obj_dma
    import dkong3_obj_dma_pkg::*;
#(
    parameter int unsigned       LEN      = LEN_DEF,
    parameter logic [SRC_AW-1:0] SRC_BASE = SRC_BASE_DEF,
    parameter int unsigned       RD_LAT   = RD_LAT_DEF
) (
    input  logic             I_CLK_24M,
    input  logic             I_RESETn,
    input  logic             I_CE,
    input  logic             I_START_WRn,
    input  logic             I_VBLK,
    input  logic             I_AUTO,
    input  logic             I_BANK,
`ifdef OBJ_DMA_FLIPY_EN
    input  logic             I_FLIPY,
`endif
    dkong3_obj_dma_if.master bus,
    output logic             O_BUSY
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(LEN - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);

    dma_state_t        state, state_d;
    logic [CNT_W-1:0]  count, count_d;
    logic [LAT_W-1:0]  lat, lat_d;
    logic              bank_l, bank_d;
    logic              flip_l, flip_d;
    logic              pending;
    logic              pend_clr_c;

    logic              busrq, busrq_d;
    logic              busy, busy_d;
    logic              src_rd, src_rd_d;
    logic [SRC_AW-1:0] src_a, src_a_d;
    obj_wr_t           obj, obj_d;
    logic              obj_ce, obj_ce_d;
    logic [DW-1:0]     byte_c;

    dkong3_obj_dma_trig u_trig (
        .I_CLK_24M   (I_CLK_24M),
        .I_RESETn    (I_RESETn),
        .I_START_WRn (I_START_WRn),
        .I_VBLK      (I_VBLK),
        .I_AUTO      (I_AUTO),
        .pend_clr    (pend_clr_c),
        .pending     (pending)
    );

    // State and output registers
    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state  <= IDLE;
            count  <= '0;
            lat    <= '0;
            bank_l <= 1'b0;
            flip_l <= 1'b0;
            busrq  <= 1'b0;
            busy   <= 1'b0;
            src_rd <= 1'b0;
            src_a  <= '0;
            obj    <= '0;
            obj_ce <= 1'b0;
        end else begin
            state  <= state_d;
            count  <= count_d;
            lat    <= lat_d;
            bank_l <= bank_d;
            flip_l <= flip_d;
            busrq  <= busrq_d;
            busy   <= busy_d;
            src_rd <= src_rd_d;
            src_a  <= src_a_d;
            obj    <= obj_d;
            obj_ce <= obj_ce_d;
        end
    end

    // Next state; losing the grant freezes READ/WAIT/WRITE in place
    always_comb begin
        state_d    = state;
        count_d    = count;
        lat_d      = lat;
        bank_d     = bank_l;
        flip_d     = flip_l;
        pend_clr_c = 1'b0;
        if (I_CE) begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state_d    = REQ;
                        count_d    = '0;
                        bank_d     = I_BANK;
`ifdef OBJ_DMA_FLIPY_EN
                        flip_d     = I_FLIPY;
`else
                        flip_d     = 1'b0;
`endif
                        pend_clr_c = 1'b1;
                    end
                end
                REQ: begin
                    if (bus.I_BUSAK) state_d = READ;
                end
                READ: begin
                    if (bus.I_BUSAK) begin
                        state_d = WAIT;
                        lat_d   = LAT_INIT;
                    end
                end
                WAIT: begin
                    if (bus.I_BUSAK) begin
                        if (lat == LAT_W'(1)) state_d = WRITE;
                        lat_d = lat - LAT_W'(1);
                    end
                end
                WRITE: begin
                    if (bus.I_BUSAK) begin
                        if (count == LAST) begin
                            state_d = DONE;
                        end else begin
                            count_d = count + CNT_W'(1);
                            state_d = READ;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs; the write beat fires on WAIT->WRITE
    always_comb begin
        busrq_d  = (state_d != IDLE) && (state_d != DONE);
        busy_d   = busrq_d;
        src_rd_d = (state_d == READ) && bus.I_BUSAK;
        src_a_d  = src_a;
        obj_d    = obj;
        obj_ce_d = 1'b0;
        byte_c   = bus.I_SRC_D;
        if (flip_l && (count[1:0] == 2'b00)) byte_c = flip_y(bus.I_SRC_D);
        if (state_d == READ) src_a_d = SRC_BASE + SRC_AW'(count_d);
        if ((state == WAIT) && (state_d == WRITE)) begin
            obj_d.a  = {bank_l, count[8:0]};
            obj_d.d  = byte_c;
            obj_ce_d = 1'b1;
        end
    end

    assign bus.O_BUSRQ      = busrq;
    assign bus.O_SRC_RD     = src_rd;
    assign bus.O_SRC_A      = src_a;
    assign bus.O_OBJ_DMA_A  = obj.a;
    assign bus.O_OBJ_DMA_D  = obj.d;
    assign bus.O_OBJ_DMA_CE = obj_ce;
    assign O_BUSY           = busy;

endmodule

// File: tb/tb_dkong3_obj_dma.sv
// Scoreboard bench for dkong3_obj_dma: expected write beats are queued at trigger
// time and a separate monitor pops/compares on every object-RAM write strobe.
module tb_dkong3_obj_dma;

    localparam int unsigned N = 384;

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
    } exp_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic ce        = 1'b0;
    logic start_wrn = 1'b1;
    logic vblk      = 1'b0;
    logic auto_en   = 1'b0;
    logic bank      = 1'b0;
    logic flipy     = 1'b0;
    logic busy;
    logic [7:0] key = 8'h00;

    int total  = 0;
    int bad    = 0;
    int wr_cnt = 0;
    int ce_div = 0;
    int base;
    exp_t sbq[$];

    dkong3_obj_dma_if bus ();

    assign bus.I_SRC_D = bus.O_SRC_A[7:0] + key;

    dkong3_obj_dma dut (
        .I_CLK_24M   (clk),
        .I_RESETn    (rst_n),
        .I_CE        (ce),
        .I_START_WRn (start_wrn),
        .I_VBLK      (vblk),
        .I_AUTO      (auto_en),
        .I_BANK      (bank),
`ifdef OBJ_DMA_FLIPY_EN
        .I_FLIPY     (flipy),
`endif
        .bus         (bus),
        .O_BUSY      (busy)
    );

    initial forever #20 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ce_div++;
        ce = (ce_div % 4 == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe consumes exactly one expected beat
    initial begin : mon
        exp_t e;
        logic ce_prev;
        ce_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.O_OBJ_DMA_CE === 1'b1) begin
                wr_cnt++;
                if (ce_prev) begin
                    total++;
                    bad++;
                    $display("FAIL wr_pulse_width: strobe high on consecutive clocks, want one clock");
                end
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: a=%0h d=%0h, want no write", bus.O_OBJ_DMA_A, bus.O_OBJ_DMA_D);
                end else begin
                    e = sbq.pop_front();
                    check("wr_addr", 32'(bus.O_OBJ_DMA_A), 32'(e.a));
                    check("wr_data", 32'(bus.O_OBJ_DMA_D), 32'(e.d));
                end
            end
            ce_prev = bus.O_OBJ_DMA_CE;
        end
    end

    task automatic push_xfer(input logic b, input logic fl);
        for (int i = 0; i < N; i++) begin
            exp_t e;
            logic [7:0] d;
            d = 8'(i) + key;
            if (fl && (i % 4 == 0)) d = 8'd240 - d;
            e.a = {b, 9'(i)};
            e.d = d;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_wrn = 1'b0;
        wait_clks(2);
        start_wrn = 1'b1;
        wait_clks(2);
    endtask

    task automatic wait_busy(input logic v, input int max, input string name);
        int k;
        k = 0;
        while (busy !== v && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(busy), 32'(v));
    endtask

    task automatic wait_wr(input int target, input int max, input string name);
        int k;
        k = 0;
        while (wr_cnt < target && k < max) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busrq"},  32'(bus.O_BUSRQ), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_src_rd"}, 32'(bus.O_SRC_RD), 32'd0);
        check({tag, "_src_a"},  32'(bus.O_SRC_A), 32'd0);
        check({tag, "_obj_a"},  32'(bus.O_OBJ_DMA_A), 32'd0);
        check({tag, "_obj_d"},  32'(bus.O_OBJ_DMA_D), 32'd0);
        check({tag, "_obj_ce"}, 32'(bus.O_OBJ_DMA_CE), 32'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int snap;
        bus.I_BUSAK = 1'b1;
        wait_clks(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wait_clks(4);

        // CPU trigger, bank 0, grant always present
        key = 8'h00;
        push_xfer(1'b0, 1'b0);
        pulse_start();
        wait_busy(1'b1, 50, "t1_busy_rise");
        check("t1_busrq", 32'(bus.O_BUSRQ), 32'd1);
        wait_busy(1'b0, 8000, "t1_busy_fall");
        check("t1_q_empty", 32'(sbq.size()), 32'd0);
        check("t1_count", 32'(wr_cnt), 32'(N));
        check("t1_busrq_drop", 32'(bus.O_BUSRQ), 32'd0);
        wait_clks(8);

        // Auto vblank trigger into bank 1; bank input toggles mid-transfer
        key = 8'h35;
        bank = 1'b1;
        auto_en = 1'b1;
        base = wr_cnt;
        push_xfer(1'b1, 1'b0);
        vblk = 1'b1;
        wait_busy(1'b1, 50, "t2_busy_rise");
        wait_wr(base + 100, 3000, "t2_reach100");
        bank = 1'b0;
        wait_busy(1'b0, 8000, "t2_busy_fall");
        check("t2_q_empty", 32'(sbq.size()), 32'd0);
        vblk = 1'b0;
        auto_en = 1'b0;
        wait_clks(8);

        // Grant withheld, then dropped after byte 100
        key = 8'h5a;
        base = wr_cnt;
        bus.I_BUSAK = 1'b0;
        push_xfer(1'b0, 1'b0);
        pulse_start();
        wait_clks(50);
        check("t3_req_held", 32'(bus.O_BUSRQ), 32'd1);
        check("t3_busy_held", 32'(busy), 32'd1);
        check("t3_no_wr_ungranted", 32'(wr_cnt), 32'(base));
        bus.I_BUSAK = 1'b1;
        wait_wr(base + 101, 3000, "t3_reach101");
        bus.I_BUSAK = 1'b0;
        snap = wr_cnt;
        wait_clks(20);
        check("t3_no_wr_dropped", 32'(wr_cnt), 32'(snap));
        check("t3_src_rd_frozen", 32'(bus.O_SRC_RD), 32'd0);
        check("t3_busrq_frozen", 32'(bus.O_BUSRQ), 32'd1);
        bus.I_BUSAK = 1'b1;
        wait_busy(1'b0, 8000, "t3_busy_fall");
        check("t3_q_empty", 32'(sbq.size()), 32'd0);
        check("t3_count", 32'(wr_cnt - base), 32'(N));
        wait_clks(8);

        // Two extra triggers while busy queue exactly one follow-on transfer
        key = 8'h11;
        base = wr_cnt;
        push_xfer(1'b0, 1'b0);
        push_xfer(1'b0, 1'b0);
        pulse_start();
        wait_busy(1'b1, 50, "t4_busy_rise");
        wait_wr(base + 50, 3000, "t4_reach50");
        pulse_start();
        wait_wr(base + 100, 3000, "t4_reach100");
        pulse_start();
        wait_wr(base + 2 * N, 12000, "t4_reach_all");
        wait_busy(1'b0, 200, "t4_busy_fall");
        wait_clks(300);
        check("t4_stays_idle", 32'(busy), 32'd0);
        check("t4_q_empty", 32'(sbq.size()), 32'd0);
        check("t4_count", 32'(wr_cnt - base), 32'(2 * N));

        // Reset mid-transfer aborts; a new trigger restarts from dest 0
        key = 8'h00;
        base = wr_cnt;
        push_xfer(1'b0, 1'b0);
        pulse_start();
        wait_wr(base + 200, 3000, "t5_reach200");
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        sbq.delete();
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
`ifdef OBJ_DMA_FLIPY_EN
        flipy = 1'b1;
`endif
        base = wr_cnt;
        push_xfer(1'b0, flipy);
        pulse_start();
        wait_busy(1'b1, 50, "t5_busy_rise");
        wait_busy(1'b0, 8000, "t5_busy_fall");
        check("t5_q_empty", 32'(sbq.size()), 32'd0);
        check("t5_count", 32'(wr_cnt - base), 32'(N));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
